// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / pipeline-register enables, flushes and bubbles.
// Latency: control outputs are combinational from state and inputs; mem_err and counters are registered.
// Backpressure: a memory wait freezes PC..EX/MEM and bubbles WB. A hung memory halts the core until rst.
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int R_ADRESS_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [R_ADRESS_WIDTH-1:0] id_rs1,
  input  logic [R_ADRESS_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [R_ADRESS_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      idex_en,
  output logic                      exmem_en,
  output logic                      memwb_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      memwb_bubble,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  // Wait counter only has to reach MEM_TIMEOUT-1; with the watchdog off it may wrap freely.
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] TO_LAST = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t         state, next_state;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           err_set;
  logic           mem_stall;
  logic           load_use;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Next-state and control outputs: memory stall > taken branch > load-use > free-run.
  always_comb begin
    next_state   = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;

    if (state == HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      // WB still advances but takes a bubble so its instruction retires only once.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // The load-use consumer sits in a flushed slot, so no stall is needed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    case (state)
      RUN: begin
        if (mem_stall) begin
          next_state   = MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        // Dropping mem_req counts as a release just like mem_ready.
        if (!mem_stall) begin
          next_state = RUN;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
          next_state = HALT;
          err_set    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: next_state = HALT;
    endcase

    // Reset overrides everything: freeze all registers and load bubbles.
    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  // State, wait counter and sticky watchdog error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // Saturating performance counters; HALT cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (state != HALT) && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if ((ifid_flush || idex_flush) && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table vectors, corner sequences, random vs model.
// Latency: one stimulus vector per clock; outputs sampled mid-cycle, registers sampled after the edge.
// Backpressure: memory waits and watchdog halts exercised by directed and random stimulus.
module tb_pipe_hazard_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [31:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.R_ADRESS_WIDTH(5), .MEM_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Output vector order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [7:0] O_RST   = 8'b00000_111;
  localparam logic [7:0] O_HALT  = 8'b00000_000;
  localparam logic [7:0] O_MEMST = 8'b00001_001;
  localparam logic [7:0] O_BR    = 8'b11111_110;
  localparam logic [7:0] O_LU    = 8'b00111_010;
  localparam logic [7:0] O_NONE  = 8'b11111_000;

  logic [7:0] out_v;
  assign out_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       bt;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [7:0] exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: consecutive stalled cycles of the current access, halt flag, counters.
  int   m_run;
  bit   m_halt;
  bit   m_err;
  int   m_sc;
  int   m_fc;

  function automatic in_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                             logic [4:0] rd, logic mr, logic bt, logic mreq, logic mrdy);
    in_t x;
    x.rst = r; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
    x.rd = rd; x.mr = mr; x.bt = bt; x.mreq = mreq; x.mrdy = mrdy;
    return x;
  endfunction

  function automatic logic [7:0] model_out(in_t x);
    bit lu;
    if (x.rst) return O_RST;
    if (m_halt) return O_HALT;
    if (x.mreq && !x.mrdy) return O_MEMST;
    if (x.bt) return O_BR;
    lu = x.mr && (x.rd != 0) && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
    return lu ? O_LU : O_NONE;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x);
    rst = x.rst; id_rs1 = x.rs1; id_rs2 = x.rs2; id_uses_rs1 = x.u1; id_uses_rs2 = x.u2;
    ex_rd = x.rd; ex_mem_read = x.mr; ex_branch_taken = x.bt; mem_req = x.mreq; mem_ready = x.mrdy;
  endtask

  // One clock: drive, compare against the model mid-cycle, clock, advance the model.
  task automatic cycle(input in_t x, input string nm, output logic [7:0] got);
    logic [7:0] e;
    drive(x);
    #3;
    e   = model_out(x);
    got = out_v;
    chk({nm, " outs"}, out_v, e);
    chk({nm, " mem_err"}, mem_err, m_err);
`ifdef PIPE_CTRL_PERF_EN
    chk({nm, " stall_cycles"}, stall_cycles, m_sc);
    chk({nm, " flush_count"}, flush_count, m_fc);
`else
    chk({nm, " stall_cycles"}, stall_cycles, 0);
    chk({nm, " flush_count"}, flush_count, 0);
`endif
    @(posedge clk);
    if (x.rst) begin
      m_run = 0; m_halt = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else if (!m_halt) begin
      if (x.mreq && !x.mrdy) begin
        m_run++;
        if (TO != 0 && m_run == TO) begin
          m_halt = 1; m_err = 1;
        end
      end else begin
        m_run = 0;
      end
      if (!e[7]) m_sc++;
      if (e[2] || e[1]) m_fc++;
    end
    #1;
  endtask

  vec_t       tbl[13];
  in_t        idle, stl, rdy, rstv;
  logic [7:0] g;
  int         hang;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stl  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rdy  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    rstv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0), O_LU};
    tbl[1]  = '{mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0), O_NONE};
    tbl[2]  = '{mk(0, 1, 7, 0, 1, 7, 1, 0, 0, 0), O_LU};
    tbl[3]  = '{mk(0, 1, 7, 1, 0, 7, 1, 0, 0, 0), O_NONE};
    tbl[4]  = '{mk(0, 7, 2, 0, 1, 7, 1, 0, 0, 0), O_NONE};
    tbl[5]  = '{mk(0, 9, 9, 1, 1, 9, 0, 0, 0, 0), O_NONE};
    tbl[6]  = '{mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0), O_BR};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_BR};
    tbl[8]  = '{mk(0, 5, 0, 1, 0, 5, 1, 1, 1, 0), O_MEMST};
    tbl[9]  = '{mk(0, 5, 0, 1, 0, 5, 1, 0, 1, 1), O_LU};
    tbl[10] = '{mk(0, 3, 3, 1, 1, 3, 1, 0, 0, 0), O_LU};
    tbl[11] = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_RST};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_NONE};

    // Initial reset: registers are unknown until the first edge.
    drive(rstv);
    #1;
    @(posedge clk);
    #1;
    m_run = 0; m_halt = 0; m_err = 0; m_sc = 0; m_fc = 0;

    // Reset state as seen after the first reset edge.
    cycle(rstv, "reset", g);
    chk("reset outs const", g, O_RST);

    // Table vectors.
    for (int k = 0; k < 13; k++) begin
      cycle(tbl[k].i, $sformatf("tbl%0d", k), g);
      chk($sformatf("tbl%0d const", k), g, tbl[k].exp);
    end

    // Memory wait: three stalled cycles, then release with all enables high.
    cycle(rstv, "mw rst", g);
    for (int k = 0; k < 3; k++) begin
      cycle(stl, "mw stall", g);
      chk("mw stall const", g, O_MEMST);
    end
    cycle(rdy, "mw release", g);
    chk("mw release const", g, O_NONE);
`ifdef PIPE_CTRL_PERF_EN
    chk("mw stall_cycles const", stall_cycles, 3);
`endif

    // Branch held through a two-cycle wait: flush only on the release cycle.
    cycle(rstv, "bw rst", g);
    for (int k = 0; k < 2; k++) begin
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "bw stall", g);
      chk("bw stall const", g, O_MEMST);
    end
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "bw release", g);
    chk("bw release const", g, O_BR);
    cycle(idle, "bw idle", g);
`ifdef PIPE_CTRL_PERF_EN
    chk("bw flush_count const", flush_count, 1);
    chk("bw stall_cycles const", stall_cycles, 2);
`endif

    // Watchdog: 16 stalled cycles then HALT with mem_err; only rst recovers.
    cycle(rstv, "wd rst", g);
    for (int k = 0; k < TO; k++) begin
      cycle(stl, "wd stall", g);
      chk("wd stall const", g, O_MEMST);
    end
    chk("wd mem_err set", mem_err, 1);
    cycle(rdy, "wd halt ready", g);
    chk("wd halt const", g, O_HALT);
    cycle(mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0), "wd halt branch", g);
    chk("wd halt branch const", g, O_HALT);
    cycle(rstv, "wd rst2", g);
    chk("wd rst const", g, O_RST);
    cycle(idle, "wd run", g);
    chk("wd run const", g, O_NONE);
    chk("wd mem_err clear", mem_err, 0);

    // Reset pulsed in the second cycle of a wait.
    cycle(idle, "rm idle", g);
    cycle(stl, "rm stall1", g);
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rm rst", g);
    chk("rm rst const", g, O_RST);
    chk("rm stall_cycles zero", stall_cycles, 0);
    chk("rm flush_count zero", flush_count, 0);
    cycle(rdy, "rm run", g);
    chk("rm run const", g, O_NONE);

    // Random stimulus against the model, with occasional hung-memory bursts.
    hang = 0;
    for (int n = 0; n < 3000; n++) begin
      in_t x;
      if (hang == 0 && $urandom_range(0, 199) == 0) hang = 20;
      x.rst  = ($urandom_range(0, 99) == 0);
      x.rs1  = 5'($urandom_range(0, 3));
      x.rs2  = 5'($urandom_range(0, 3));
      x.u1   = 1'($urandom);
      x.u2   = 1'($urandom);
      x.rd   = 5'($urandom_range(0, 3));
      x.mr   = 1'($urandom);
      x.bt   = ($urandom_range(0, 3) == 0);
      x.mreq = (hang > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      x.mrdy = (hang > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (hang > 0) hang--;
      cycle(x, "rand", g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequencing controller for the five-stage RV32 pipeline. It drives the write-enables and flush/bubble controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a watchdog that halts the core on a hung memory. The block sits beside the pipeline registers, takes hazard information from ID, EX and MEM, and owns no datapath.

## Interface
- `R_ADRESS_WIDTH`, 5: register index width.
- `MEM_TIMEOUT`, 16: maximum stalled cycles per memory access before halt. Legal values are 0 (watchdog off) or ≥2.
- `CNT_WIDTH`, 32: width of the performance counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `id_rs1`, `id_rs2`  in  R_ADRESS_WIDTH: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1: the ID instruction reads that source.
- `ex_rd`  in  R_ADRESS_WIDTH: destination register of the instruction in EX.
- `ex_mem_read`  in  1: the instruction in EX is a load.
- `ex_branch_taken`  in  1: a branch or jump in EX resolved taken.
- `mem_req`  in  1: the instruction in MEM accesses data memory.
- `mem_ready`  in  1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1: register load enables.
- `ifid_flush`, `idex_flush`, `memwb_bubble`  out  1: load a NOP/bubble instead of the register input.
- `mem_err`  out  1: sticky watchdog error.
- `stall_cycles`, `flush_count`  out  CNT_WIDTH: performance counters (macro-dependent).

## Operation
States: RUN, MEM_WAIT, HALT. Reset enters RUN.

Hazard terms, evaluated combinationally:
- `mem_stall` = `mem_req && !mem_ready`.
- `load_use` = `ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd))`.

Priority, highest first:

1. **mem_stall** (RUN or MEM_WAIT):
   - `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0.
   - `memwb_en` = 1 with `memwb_bubble` = 1, so the instruction in WB retires exactly once.
   - Other flushes are 0.
2. **ex_branch_taken**:
   - All enables are 1.
   - `ifid_flush` = `idex_flush` = 1.
   - `load_use` is ignored, because its instruction is flushed.
3. **load_use**:
   - `pc_en` = `ifid_en` = 0.
   - `idex_en` = 1 with `idex_flush` = 1.
   - `exmem_en` = `memwb_en` = 1.
4. **None of the above**: all enables are 1 and all flush/bubble outputs are 0.

Transitions:
- RUN → MEM_WAIT on `mem_stall`. The wait counter is set to 1.
- MEM_WAIT with `mem_ready` → RUN. This release cycle applies rules 2–4 exactly as RUN does; a branch held during the wait is flushed in this cycle.
- MEM_WAIT with `!mem_ready`:
  - If `MEM_TIMEOUT != 0` and wait counter == `MEM_TIMEOUT-1` → HALT, and `mem_err` is set on the next edge.
  - Otherwise the wait counter increments.
- HALT: all enables are 0 and all flushes are 0. Inputs are ignored. The block leaves HALT only through `rst`.
- `mem_req` deasserting while in MEM_WAIT counts as release; the block returns to RUN.

## Timing
- All outputs except `mem_err` and the counters are combinational from state and inputs. State, the wait counter, `mem_err` and the counters update on the rising edge of `clk`.
- While `rst` = 1:
  - All enables are 0.
  - `ifid_flush` = `idex_flush` = 1 and `memwb_bubble` = 1.
  - The first edge with `rst` high clears state to RUN, the wait counter to 0, `mem_err` to 0 and both counters to 0.
- `rst` asserted mid-wait or in HALT aborts immediately, with the same values as above.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 flushed slots.
- A memory access with N cycles of `!mem_ready` stalls exactly N cycles.
- With the watchdog on, HALT is entered after exactly `MEM_TIMEOUT` consecutive stalled cycles, counting the RUN entry cycle. `mem_err` is visible on the edge after the last stalled cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle where `pc_en` = 0 in RUN or MEM_WAIT.
  - `flush_count` increments on every cycle with `ifid_flush || idex_flush` outside reset.
  - Both counters saturate at all-ones and clear on `rst`.
- Not defined: no counter flops are built, and both outputs are tied to 0.

## Test plan
- **Load-use:** `ex_mem_read` = 1, `ex_rd` = 5, `id_rs1` = 5, `id_uses_rs1` = 1 → one cycle with `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1, then all enables 1. With `ex_rd` = 0 instead → no stall.
- **Branch with load-use:** `ex_branch_taken` = 1 together with a load-use match → `ifid_flush` = `idex_flush` = 1, `pc_en` = 1, no stall cycle.
- **Memory wait:** `mem_req` = 1, `mem_ready` low for 3 cycles then high → 3 cycles with `pc_en` = 0 and `memwb_bubble` = 1; release cycle has all enables 1. With the macro on, `stall_cycles` = 3.
- **Branch during wait:** `ex_branch_taken` held during a 2-cycle memory wait → no flush during the wait; flush asserted only on the `mem_ready` cycle; `flush_count` = 1.
- **Watchdog:** `MEM_TIMEOUT` = 16, `mem_req` = 1, `mem_ready` never asserted → `mem_err` = 1 after 16 stalled cycles; all enables stay 0 in HALT; `rst` for 1 cycle returns to RUN with `mem_err` = 0.
- **Reset mid-wait:** `rst` pulsed in cycle 2 of a memory wait → the next cycle is in RUN with all outputs at their reset values; the counters read 0.
